// File: rtl/vote_run_encoder_if.sv
// Record stream between the run-length encoder and its consumer.
// The producer drives data/valid and the consumer drives ready.
interface vote_run_encoder_if #(
    parameter int LEN_W = 7
);
    logic [LEN_W:0] rec_data;
    logic           rec_valid;
    logic           rec_ready;

    modport master (output rec_data, output rec_valid, input rec_ready);
    modport slave  (input rec_data, input rec_valid, output rec_ready);
endinterface

// File: rtl/vote_run_encoder.sv
// Collapses runs of identical voter decisions into {level, length} records
// and buffers them in a small FIFO drained over a valid/ready handshake.
module vote_run_encoder #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       vote_in,
    input  logic                       vote_valid,
    input  logic                       flush,
    vote_run_encoder_if.master         rec,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] MAXLEN = {LEN_W{1'b1}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_r, state_nxt_s;
    logic             level_r, level_nxt_s;
    logic [LEN_W-1:0] len_r, len_nxt_s;
    logic             emit_s;
    logic [LEN_W:0]   emit_rec_s;

    logic [LEN_W:0]   mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             full_s, pop_s, push_ok_s, rec_valid_s;

    // Run tracker state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            level_r <= 1'b0;
            len_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            level_r <= level_nxt_s;
            len_r   <= len_nxt_s;
        end
    end

    // Run tracker next state and record emission; flush outranks the sample
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        len_nxt_s   = len_r;
        emit_s      = 1'b0;
        emit_rec_s  = {level_r, len_r};
        if (ena && flush) begin
            emit_s = (state_r == RUN);
            if (vote_valid) begin
                state_nxt_s = RUN;
                level_nxt_s = vote_in;
                len_nxt_s   = {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                state_nxt_s = IDLE;
            end
        end else if (ena && vote_valid) begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = RUN;
                    level_nxt_s = vote_in;
                    len_nxt_s   = {{(LEN_W-1){1'b0}}, 1'b1};
                end
                RUN: begin
                    if (vote_in != level_r) begin
                        emit_s      = 1'b1;
                        level_nxt_s = vote_in;
                        len_nxt_s   = {{(LEN_W-1){1'b0}}, 1'b1};
                    end else if (len_r == MAXLEN) begin
                        // chunk long runs instead of letting the counter wrap
                        emit_s    = 1'b1;
                        len_nxt_s = {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        len_nxt_s = len_r + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign rec_valid_s = (count_r != {CW{1'b0}});
    assign full_s      = (count_r == CW'(DEPTH));
    assign pop_s       = rec_valid_s && rec.rec_ready;
    assign push_ok_s   = emit_s && (!full_s || pop_s);

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(LEN_W+1){1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= emit_rec_s;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (push_ok_s && !pop_s) begin
                count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (pop_s && !push_ok_s) begin
                count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            end
            if (emit_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign rec.rec_valid = rec_valid_s;
    assign rec.rec_data  = rec_valid_s ? mem_r[rd_ptr_r] : {(LEN_W+1){1'b0}};
    assign fifo_count    = count_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_vote_run_encoder.sv
// Directed bench for vote_run_encoder with hand-computed records.
module tb_vote_run_encoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       vote_in;
    logic       vote_valid;
    logic       flush;
    logic [2:0] fifo_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] log_q [$];

    vote_run_encoder_if #(.LEN_W(7)) rec_if ();

    vote_run_encoder #(.DEPTH(4), .LEN_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .vote_in    (vote_in),
        .vote_valid (vote_valid),
        .flush      (flush),
        .rec        (rec_if),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // log any record accepted on the coming edge, then sample 1 time unit after it
    task automatic step();
        if (rec_if.rec_valid && rec_if.rec_ready) log_q.push_back(rec_if.rec_data);
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic b);
        vote_in    = b;
        vote_valid = 1'b1;
        step();
        vote_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp [5], input int n);
        check_eq({tag, "_count"}, log_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_%0d", tag, i),
                     (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
        end
        log_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; vote_in = 1'b0; vote_valid = 1'b0; flush = 1'b0;
        rec_if.rec_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_eq("rst_valid", rec_if.rec_valid, 1'b0);
        check_eq("rst_data", rec_if.rec_data, 8'h00);
        check_eq("rst_count", fifo_count, 3'd0);
        check_eq("rst_ovf", overflow, 1'b0);

        // basic stream 4x0, 5x1, 6x0, flush
        rec_if.rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) sample(1'b0);
        check_eq("s_none", rec_if.rec_valid, 1'b0);
        sample(1'b1);
        check_eq("s_rec0", rec_if.rec_data, 8'h04);
        for (int i = 0; i < 4; i++) sample(1'b1);
        sample(1'b0);
        check_eq("s_rec1", rec_if.rec_data, 8'h85);
        for (int i = 0; i < 5; i++) sample(1'b0);
        do_flush();
        check_eq("s_rec2", rec_if.rec_data, 8'h06);
        step();
        check_eq("s_empty", rec_if.rec_valid, 1'b0);
        check_log("stream", '{8'h04, 8'h85, 8'h06, 8'h00, 8'h00}, 3);

        // saturation: 130 ones then flush
        for (int i = 1; i <= 130; i++) begin
            sample(1'b1);
            if (i == 127) check_eq("sat_127", rec_if.rec_valid, 1'b0);
            if (i == 128) check_eq("sat_128", rec_if.rec_data, 8'hFF);
        end
        do_flush();
        check_eq("sat_tail", rec_if.rec_data, 8'h83);
        step();
        check_log("sat", '{8'hFF, 8'h83, 8'h00, 8'h00, 8'h00}, 2);

        // overflow with consumer stalled
        rec_if.rec_ready = 1'b0;
        sample(1'b0); sample(1'b1); sample(1'b0);
        sample(1'b1); sample(1'b0); sample(1'b1);
        check_eq("ovf_count", fifo_count, 3'd4);
        check_eq("ovf_flag", overflow, 1'b1);
        check_eq("ovf_head", rec_if.rec_data, 8'h01);
        rec_if.rec_ready = 1'b1;
        repeat (4) step();
        check_eq("ovf_drained", fifo_count, 3'd0);
        check_eq("ovf_valid", rec_if.rec_valid, 1'b0);
        check_eq("ovf_sticky", overflow, 1'b1);
        check_log("ovf", '{8'h01, 8'h81, 8'h01, 8'h81, 8'h00}, 4);

        // reset mid-run with two records queued
        rec_if.rec_ready = 1'b0;
        sample(1'b0); sample(1'b1);
        check_eq("mid_count", fifo_count, 3'd2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_valid", rec_if.rec_valid, 1'b0);
        check_eq("mid_data", rec_if.rec_data, 8'h00);
        check_eq("mid_fcount", fifo_count, 3'd0);
        check_eq("mid_ovf", overflow, 1'b0);
        step(); step();
        rst_n = 1'b1;
        sample(1'b1); sample(1'b0);
        check_eq("fresh_rec", rec_if.rec_data, 8'h81);
        check_eq("fresh_count", fifo_count, 3'd1);

        // full FIFO with pop and push on the same edge
        sample(1'b1); sample(1'b0); sample(1'b1);
        check_eq("full_count", fifo_count, 3'd4);
        rec_if.rec_ready = 1'b1;
        sample(1'b0);
        check_eq("pp_count", fifo_count, 3'd4);
        check_eq("pp_ovf", overflow, 1'b0);
        repeat (4) step();
        check_eq("pp_empty", fifo_count, 3'd0);
        check_log("pp", '{8'h81, 8'h01, 8'h81, 8'h01, 8'h81}, 5);

        // flush together with a new sample
        do_flush();
        step();
        log_q.delete();
        sample(1'b0); sample(1'b0); sample(1'b0);
        flush = 1'b1; vote_valid = 1'b1; vote_in = 1'b1;
        step();
        flush = 1'b0; vote_valid = 1'b0;
        check_eq("fv_rec", rec_if.rec_data, 8'h03);
        sample(1'b0);
        check_eq("fv_newrun", rec_if.rec_data, 8'h81);
        rec_if.rec_ready = 1'b0;

        // ena low freezes the tracker, pops still proceed
        sample(1'b0); sample(1'b0);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) sample(1'b1);
        do_flush();
        check_eq("ena_count", fifo_count, 3'd1);
        check_eq("ena_head", rec_if.rec_data, 8'h81);
        rec_if.rec_ready = 1'b1;
        step();
        rec_if.rec_ready = 1'b0;
        check_eq("ena_pop", fifo_count, 3'd0);
        ena = 1'b1;
        sample(1'b1);
        check_eq("ena_resume", rec_if.rec_data, 8'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
